// File: rtl/game_flow_ctrl_pkg.sv
// Shared encodings for the snake game flow controller: screen states,
// direction one-hots, key indices and the opposite-direction helper.
package game_flow_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_START = 4'b0001,
        ST_SPEED = 4'b0010,
        ST_PLAY  = 4'b0100,
        ST_END   = 4'b1000
    } state_t;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int NUM_KEYS  = 4;

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_key_debounce.sv
// One active-low push-button: 2-FF synchroniser, stability counter and a
// single-cycle press event on the released -> pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int DB_W         = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic kp
);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync1, sync2, level;
    logic [DB_W-1:0] cnt;

    // level is the accepted key level; 1 means released
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            kp    <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            kp    <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                kp    <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Snake game screen sequencer: debounced key events drive START/SPEED/PLAY/END,
// speed selection, direction with reversal rejection and the frame-locked move tick.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int DB_W         = 18,
    parameter int SLOW_FRAMES  = 12,
    parameter int FAST_FRAMES  = 6
) (
    input  logic       vga_clk_25,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic       frame_start,
    input  logic       game_over,
    output logic [3:0] state_m,
    output logic       speed_m,
    output logic [3:0] move_d,
    output logic       move_tick,
    output logic       play_init
);
    localparam int MAX_FRAMES = (SLOW_FRAMES > FAST_FRAMES) ? SLOW_FRAMES : FAST_FRAMES;
    localparam int FC_W       = $clog2(MAX_FRAMES + 1);

    logic [NUM_KEYS-1:0] kp, ev;
    state_t              state, state_n;
    logic                speed, speed_n;
    logic [3:0]          dir, dir_n, pend, pend_n;
    logic [FC_W-1:0]     fcnt, fcnt_n, fcnt_last;
    logic                init, init_n, tick;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DB_W(DB_W)) u_db (
            .clk (vga_clk_25),
            .rst (rst),
            .key (key[i]),
            .kp  (kp[i])
        );
    end

    // isolate the lowest set bit so only one event acts per cycle
    assign ev        = kp & (~kp + 4'd1);
    assign fcnt_last = speed ? FC_W'(FAST_FRAMES - 1) : FC_W'(SLOW_FRAMES - 1);

    always_ff @(posedge vga_clk_25) begin
        if (rst) begin
            state <= ST_START;
            speed <= 1'b0;
            dir   <= DIR_RIGHT;
            pend  <= DIR_RIGHT;
            fcnt  <= '0;
            init  <= 1'b0;
        end else begin
            state <= state_n;
            speed <= speed_n;
            dir   <= dir_n;
            pend  <= pend_n;
            fcnt  <= fcnt_n;
            init  <= init_n;
        end
    end

    always_comb begin
        state_n = state;
        speed_n = speed;
        dir_n   = dir;
        pend_n  = pend;
        fcnt_n  = fcnt;
        init_n  = 1'b0;
        tick    = 1'b0;
        case (state)
            ST_START: if (|ev) state_n = ST_SPEED;
            ST_SPEED: begin
                if (ev[KEY_UP]) begin
                    speed_n = 1'b1;
                end else if (ev[KEY_DOWN]) begin
                    speed_n = 1'b0;
                end else if (ev[KEY_RIGHT]) begin
                    state_n = ST_PLAY;
                    init_n  = 1'b1;
                    dir_n   = DIR_RIGHT;
                    pend_n  = DIR_RIGHT;
                    fcnt_n  = '0;
                end
            end
            ST_PLAY: begin
                if (game_over) begin
                    state_n = ST_END;
                end else begin
                    // reversal is judged against the committed direction, not pending
                    if (|ev && ev != dir && ev != opposite(dir)) pend_n = ev;
                    if (frame_start) begin
                        if (fcnt == fcnt_last) begin
                            tick   = 1'b1;
                            fcnt_n = '0;
                            dir_n  = pend;
                        end else begin
                            fcnt_n = fcnt + FC_W'(1);
                        end
                    end
                end
            end
            ST_END: begin
                if (|ev) begin
                    state_n = ST_START;
                    dir_n   = DIR_RIGHT;
                    pend_n  = DIR_RIGHT;
                end
            end
            default: state_n = ST_START;
        endcase
    end

    assign state_m   = state;
    assign speed_m   = speed;
    assign move_d    = dir;
    assign move_tick = tick & ~rst;
    assign play_init = init;

endmodule
